fm_demod_qarctan: RTL and testbench

- FM discriminator sitting directly downstream of the complex channel FIR. Pops one I/Q sample pair from the FIR's two output FIFOs and forms the conjugate product with the previous sample.
- Computes the phase step with the quantized quadrant arctangent, scales it by the demod gain and pushes one real audio-rate sample to a single output FIFO.
- Fixed-point throughout (Q.BITS); arithmetic matches the team's C golden model bit-exactly.

---
 rtl/fm_demod_qarctan.sv | 174 +++++++++++++++++
 tb/tb_fm_demod_qarctan.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_demod_qarctan.sv
// FM discriminator: conjugate product with the previous I/Q sample, quadrant arctangent, demod gain.
// Latency: pop to push is DATA_WIDTH+4 cycles; one sample every DATA_WIDTH+5 cycles.
// Backpressure: a full output FIFO holds the result in S_WRITE and no further input is popped.
module fm_demod_qarctan #(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10,
    parameter int GAIN       = 758,
    parameter int QUAD1      = 804,
    parameter int QUAD3      = 2412
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] x_real_in,
    input  logic [DATA_WIDTH-1:0] x_imag_in,
    input  logic                  x_real_in_empty,
    input  logic                  x_imag_in_empty,
    output logic                  x_real_in_rd_en,
    output logic                  x_imag_in_rd_en,
    output logic [DATA_WIDTH-1:0] y_out,
    input  logic                  y_out_full,
    output logic                  y_out_wr_en
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef logic signed [DW-1:0] sword_t;
    typedef logic signed [PW-1:0] dword_t;

    localparam sword_t Q1 = sword_t'(QUAD1);
    localparam sword_t Q3 = sword_t'(QUAD3);
    localparam sword_t GN = sword_t'(GAIN);

    typedef enum logic [2:0] {
        S_READ,
        S_MULT,
        S_PREP,
        S_DIV,
        S_ANGLE,
        S_WRITE
    } state_t;

    function automatic dword_t mul(input sword_t a, input sword_t b);
        return {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
    endfunction

    // Divide by 2^BITS rounding toward zero, like C integer division.
    function automatic sword_t deq(input dword_t v);
        dword_t bias;
        bias = v[PW-1] ? {{(PW-BITS){1'b0}}, {BITS{1'b1}}} : '0;
        return sword_t'((v + bias) >>> BITS);
    endfunction

    state_t          state;
    sword_t          prev_real, prev_imag;
    sword_t          cur_real, cur_imag;
    sword_t          x_reg, y_reg;
    sword_t          base;
    logic            num_neg, y_neg;
    logic [DW-1:0]   rem, quo, den;
    logic [CW-1:0]   iter;
    sword_t          y_out_next;

    sword_t          r_calc, i_calc, abs_y, num_calc, den_calc, base_calc;
    logic [DW-1:0]   num_abs;
    logic [DW:0]     diff;
    logic            ge;
    logic [DW-1:0]   rem_nxt;
    sword_t          q_s, angle_raw, angle, y_calc;

    always_comb begin
        r_calc    = deq(mul(prev_real, cur_real)) + deq(mul(prev_imag, cur_imag));
        i_calc    = deq(mul(prev_real, cur_imag)) - deq(mul(prev_imag, cur_real));

        abs_y     = (y_reg[DW-1] ? -y_reg : y_reg) + sword_t'(1);
        if (!x_reg[DW-1]) begin
            num_calc  = (x_reg - abs_y) <<< BITS;
            den_calc  = x_reg + abs_y;
            base_calc = Q1;
        end else begin
            num_calc  = (x_reg + abs_y) <<< BITS;
            den_calc  = abs_y - x_reg;
            base_calc = Q3;
        end
        num_abs   = num_calc[DW-1] ? -num_calc : num_calc;

        // Borrow out of the trial subtraction means the shifted remainder is below den.
        diff      = {rem, quo[DW-1]} - {1'b0, den};
        ge        = ~diff[DW];
        rem_nxt   = ge ? diff[DW-1:0] : {rem[DW-2:0], quo[DW-1]};

        q_s       = num_neg ? -sword_t'(quo) : sword_t'(quo);
        angle_raw = base - deq(mul(Q1, q_s));
        angle     = y_neg ? -angle_raw : angle_raw;
        y_calc    = deq(mul(GN, angle));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_READ;
            prev_real       <= '0;
            prev_imag       <= '0;
            cur_real        <= '0;
            cur_imag        <= '0;
            x_reg           <= '0;
            y_reg           <= '0;
            base            <= '0;
            num_neg         <= 1'b0;
            y_neg           <= 1'b0;
            rem             <= '0;
            quo             <= '0;
            den             <= '0;
            iter            <= '0;
            y_out_next      <= '0;
            y_out           <= '0;
            x_real_in_rd_en <= 1'b0;
            x_imag_in_rd_en <= 1'b0;
            y_out_wr_en     <= 1'b0;
        end else begin
            x_real_in_rd_en <= 1'b0;
            x_imag_in_rd_en <= 1'b0;
            y_out_wr_en     <= 1'b0;
            case (state)
                S_READ: begin
                    if (!x_real_in_empty && !x_imag_in_empty) begin
                        x_real_in_rd_en <= 1'b1;
                        x_imag_in_rd_en <= 1'b1;
                        cur_real        <= x_real_in;
                        cur_imag        <= x_imag_in;
                        state           <= S_MULT;
                    end
                end
                S_MULT: begin
                    x_reg     <= r_calc;
                    y_reg     <= i_calc;
                    prev_real <= cur_real;
                    prev_imag <= cur_imag;
                    state     <= S_PREP;
                end
                S_PREP: begin
                    quo     <= num_abs;
                    rem     <= '0;
                    den     <= den_calc;
                    num_neg <= num_calc[DW-1];
                    y_neg   <= y_reg[DW-1];
                    base    <= base_calc;
                    iter    <= '0;
                    state   <= S_DIV;
                end
                S_DIV: begin
                    rem  <= rem_nxt;
                    quo  <= {quo[DW-2:0], ge};
                    iter <= iter + 1'b1;
                    if (iter == CW'(DW - 1))
                        state <= S_ANGLE;
                end
                S_ANGLE: begin
                    y_out_next <= y_calc;
                    state      <= S_WRITE;
                end
                S_WRITE: begin
                    if (!y_out_full) begin
                        y_out       <= y_out_next;
                        y_out_wr_en <= 1'b1;
                        state       <= S_READ;
                    end
                end
                default: state <= S_READ;
            endcase
        end
    end

endmodule

// File: tb/tb_fm_demod_qarctan.sv
// Directed bench for fm_demod_qarctan with hand-computed outputs, latency, backpressure and reset cases.
module tb_fm_demod_qarctan;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x_real_in, x_imag_in;
    logic        x_real_in_empty, x_imag_in_empty;
    logic        x_real_in_rd_en, x_imag_in_rd_en;
    logic [31:0] y_out;
    logic        y_out_full;
    logic        y_out_wr_en;

    int tests = 0;
    int fails = 0;
    int rd_cnt = 0;
    int rdi_cnt = 0;
    int wr_cnt = 0;

    always #5 clk = ~clk;

    fm_demod_qarctan dut (
        .clk             (clk),
        .rst             (rst),
        .x_real_in       (x_real_in),
        .x_imag_in       (x_imag_in),
        .x_real_in_empty (x_real_in_empty),
        .x_imag_in_empty (x_imag_in_empty),
        .x_real_in_rd_en (x_real_in_rd_en),
        .x_imag_in_rd_en (x_imag_in_rd_en),
        .y_out           (y_out),
        .y_out_full      (y_out_full),
        .y_out_wr_en     (y_out_wr_en)
    );

    always @(posedge clk) begin
        if (x_real_in_rd_en) rd_cnt <= rd_cnt + 1;
        if (x_imag_in_rd_en) rdi_cnt <= rdi_cnt + 1;
        if (y_out_wr_en) wr_cnt <= wr_cnt + 1;
    end

    task automatic do_reset();
        x_real_in_empty = 1'b1;
        x_imag_in_empty = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Presents one sample, waits for the pop, then for the push; reports latency and output.
    task automatic feed(input logic [31:0] re, input logic [31:0] im,
                        output bit ok, output int lat, output int y);
        ok = 1'b0;
        lat = 0;
        y = 0;
        x_real_in = re;
        x_imag_in = im;
        x_real_in_empty = 1'b0;
        x_imag_in_empty = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (x_real_in_rd_en) begin
                ok = 1'b1;
                break;
            end
        end
        x_real_in_empty = 1'b1;
        x_imag_in_empty = 1'b1;
        if (ok) begin
            ok = 1'b0;
            for (int n = 1; n <= 100; n++) begin
                @(negedge clk);
                if (y_out_wr_en) begin
                    ok = 1'b1;
                    lat = n;
                    y = $signed(y_out);
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        y_out_full = 1'b0;
        x_real_in = 32'd0;
        x_imag_in = 32'd0;
        x_real_in_empty = 1'b1;
        x_imag_in_empty = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (y_out !== 32'd0) begin
            fails++;
            $display("FAIL reset_y_out: got %0d expected 0", y_out);
        end
        tests++;
        if (x_real_in_rd_en !== 1'b0 || x_imag_in_rd_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_rd_en: got %b%b expected 00", x_real_in_rd_en, x_imag_in_rd_en);
        end
        tests++;
        if (y_out_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_wr_en: got %b expected 0", y_out_wr_en);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sequence();
        logic [31:0] re_v [4];
        logic [31:0] im_v [4];
        int          exp_v [4];
        bit          ok;
        int          lat, y, w0;
        re_v = '{32'd1024, 32'd1024, 32'd0, 32'd0};
        im_v = '{32'd0, 32'd0, 32'd1024, -32'sd1024};
        exp_v = '{1190, 1, 1190, 2379};
        w0 = wr_cnt;
        for (int k = 0; k < 4; k++) begin
            feed(re_v[k], im_v[k], ok, lat, y);
            tests++;
            if (!ok || y !== exp_v[k]) begin
                fails++;
                $display("FAIL seq_value[%0d]: got %0d (seen=%0d) expected %0d", k, y, ok, exp_v[k]);
            end
            tests++;
            if (lat !== 36) begin
                fails++;
                $display("FAIL seq_latency[%0d]: got %0d expected 36", k, lat);
            end
        end
        repeat (3) @(negedge clk);
        tests++;
        if (wr_cnt - w0 !== 4) begin
            fails++;
            $display("FAIL seq_write_count: got %0d expected 4", wr_cnt - w0);
        end
    endtask

    task automatic test_negative();
        bit ok;
        int lat, y;
        do_reset();
        feed(32'd1024, 32'd0, ok, lat, y);
        tests++;
        if (!ok || y !== 1190) begin
            fails++;
            $display("FAIL neg_first: got %0d expected 1190", y);
        end
        feed(32'd0, -32'sd1024, ok, lat, y);
        tests++;
        if (!ok || y !== -1190) begin
            fails++;
            $display("FAIL neg_trunc: got %0d expected -1190", y);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat, y, r0, w0;
        do_reset();
        y_out_full = 1'b1;
        x_real_in = 32'd1024;
        x_imag_in = 32'd0;
        x_real_in_empty = 1'b0;
        x_imag_in_empty = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (x_real_in_rd_en) begin
                ok = 1'b1;
                break;
            end
        end
        // Second sample (1024,0) stays available the whole time.
        @(negedge clk);
        r0 = rd_cnt;
        w0 = wr_cnt;
        repeat (36 + 50) @(negedge clk);
        tests++;
        if (!ok || rd_cnt !== r0 || wr_cnt !== w0) begin
            fails++;
            $display("FAIL bp_hold: got rd=%0d wr=%0d expected rd=%0d wr=%0d", rd_cnt, wr_cnt, r0, w0);
        end
        tests++;
        if (y_out !== 32'd0) begin
            fails++;
            $display("FAIL bp_y_stable: got %0d expected 0", y_out);
        end
        y_out_full = 1'b0;
        @(negedge clk);
        tests++;
        if (y_out_wr_en !== 1'b1 || $signed(y_out) !== 1190) begin
            fails++;
            $display("FAIL bp_release: got wr=%b y=%0d expected wr=1 y=1190", y_out_wr_en, $signed(y_out));
        end
        @(negedge clk);
        tests++;
        if (wr_cnt - w0 !== 1 || y_out_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL bp_single_write: got %0d writes expected 1", wr_cnt - w0);
        end
        tests++;
        if (x_real_in_rd_en !== 1'b1 || x_imag_in_rd_en !== 1'b1) begin
            fails++;
            $display("FAIL bp_next_pop: got %b%b expected 11", x_real_in_rd_en, x_imag_in_rd_en);
        end
        x_real_in_empty = 1'b1;
        x_imag_in_empty = 1'b1;
        ok = 1'b0;
        lat = 0;
        y = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (y_out_wr_en) begin
                ok = 1'b1;
                lat = n;
                y = $signed(y_out);
                break;
            end
        end
        tests++;
        if (!ok || y !== 1 || lat !== 36) begin
            fails++;
            $display("FAIL bp_second: got y=%0d lat=%0d expected y=1 lat=36", y, lat);
        end
    endtask

    task automatic test_reset_mid_div();
        bit ok;
        int lat, y, w0;
        do_reset();
        x_real_in = 32'd1024;
        x_imag_in = 32'd0;
        x_real_in_empty = 1'b0;
        x_imag_in_empty = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (x_real_in_rd_en) break;
        end
        x_real_in_empty = 1'b1;
        x_imag_in_empty = 1'b1;
        w0 = wr_cnt;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        tests++;
        if (wr_cnt !== w0 || y_out !== 32'd0) begin
            fails++;
            $display("FAIL rst_abort: got %0d writes y=%0d expected 0 writes y=0", wr_cnt - w0, y_out);
        end
        feed(32'd1024, 32'd0, ok, lat, y);
        tests++;
        if (!ok || y !== 1190) begin
            fails++;
            $display("FAIL rst_history_lost: got %0d expected 1190", y);
        end
    endtask

    task automatic test_stall_imag();
        bit ok;
        int lat, y, r0, ri0;
        do_reset();
        x_real_in = 32'd1024;
        x_imag_in = 32'd0;
        x_real_in_empty = 1'b0;
        x_imag_in_empty = 1'b1;
        r0 = rd_cnt;
        ri0 = rdi_cnt;
        repeat (20) @(negedge clk);
        tests++;
        if (rd_cnt !== r0 || rdi_cnt !== ri0) begin
            fails++;
            $display("FAIL stall_no_pop: got real=%0d imag=%0d pops expected 0", rd_cnt - r0, rdi_cnt - ri0);
        end
        feed(32'd1024, 32'd0, ok, lat, y);
        tests++;
        if (!ok || y !== 1190 || lat !== 36) begin
            fails++;
            $display("FAIL stall_resume: got y=%0d lat=%0d expected y=1190 lat=36", y, lat);
        end
        tests++;
        if (rd_cnt !== rdi_cnt) begin
            fails++;
            $display("FAIL pop_pairing: got real=%0d imag=%0d expected equal", rd_cnt, rdi_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_negative();
        test_backpressure();
        test_reset_mid_div();
        test_stall_imag();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
